// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified memory port arbiter: FSM state encoding and
// requester identifiers.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_DM = 1'b1
    } req_id_t;

    // Which requester owns the transaction in flight for a given busy state.
    function automatic req_id_t owner_of(arb_state_t s);
        return (s == BUSY_D) ? REQ_DM : REQ_IF;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory-side signals around the arbiter.
// slave is the arbiter's view; master is the pipeline/memory environment's view.
interface mem_port_arbiter_if;

    logic        if_req;
    logic [31:2] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;

    logic        dm_req;
    logic        dm_we;
    logic [31:2] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_done;

    logic        stall_if;
    logic        stall_mem;

    logic        mem_req;
    logic        mem_we;
    logic [31:2] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    logic        bus_err;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
        input  mem_rdata, mem_ready,
        output if_rdata, if_done, dm_rdata, dm_done, stall_if, stall_mem,
        output mem_req, mem_we, mem_addr, mem_wdata, bus_err
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
        output mem_rdata, mem_ready,
        input  if_rdata, if_done, dm_rdata, dm_done, stall_if, stall_mem,
        input  mem_req, mem_we, mem_addr, mem_wdata, bus_err
    );

endinterface

// File: rtl/mem_port_arbiter_timer.sv
// Busy-cycle wait counter; expire flags the cycle whose increment would
// bring the count to MAX_WAIT.
module mem_wait_timer #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign expire = en && (cnt == CNT_W'(MAX_WAIT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and the MEM
// stage, one word transaction at a time, with a busy-cycle timeout.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_port_arbiter_if.slave     bus
);

    arb_state_t state;
    req_id_t    owner;
    logic       dm_elig;
    logic       if_elig;
    logic       busy;
    logic       expire;

    // A requester whose done is high this cycle has just been served.
    assign dm_elig = bus.dm_req & ~bus.dm_done;
    assign if_elig = bus.if_req & ~bus.if_done;
    assign busy    = (state != IDLE);
    assign owner   = owner_of(state);

    assign bus.stall_if  = bus.if_req & ~bus.if_done;
    assign bus.stall_mem = bus.dm_req & ~bus.dm_done;

    mem_wait_timer #(
        .MAX_WAIT (MAX_WAIT),
        .CNT_W    (CNT_W)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (~busy),
        .en     (busy & ~bus.mem_ready),
        .expire (expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.if_rdata  <= '0;
            bus.dm_rdata  <= '0;
            bus.if_done   <= 1'b0;
            bus.dm_done   <= 1'b0;
            bus.bus_err   <= 1'b0;
        end else begin
            bus.if_done <= 1'b0;
            bus.dm_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (dm_elig) begin
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= bus.dm_we;
                        bus.mem_addr  <= bus.dm_addr;
                        bus.mem_wdata <= bus.dm_wdata;
                        state         <= BUSY_D;
                    end else if (if_elig) begin
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= 1'b0;
                        bus.mem_addr  <= bus.if_addr;
                        state         <= BUSY_I;
                    end
                end
                BUSY_I, BUSY_D: begin
                    // mem_ready takes precedence over a coincident timeout.
                    if (bus.mem_ready || expire) begin
                        bus.mem_req <= 1'b0;
                        state       <= IDLE;
                        if (!bus.mem_ready) begin
                            bus.bus_err <= 1'b1;
                        end
                        if (owner == REQ_DM) begin
                            bus.dm_done <= 1'b1;
                            if (!bus.mem_ready) begin
                                bus.dm_rdata <= '0;
                            end else if (!bus.mem_we) begin
                                bus.dm_rdata <= bus.mem_rdata;
                            end
                        end else begin
                            bus.if_done  <= 1'b1;
                            bus.if_rdata <= bus.mem_ready ? bus.mem_rdata : 32'h0;
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    bus.mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a simple delay-programmable memory model.
module tb_mem_port_arbiter;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    // memory model: mem_ready in the mem_delay-th cycle of a request, when enabled
    int          mem_cnt;
    int          mem_delay;
    logic        mem_en;
    logic [31:0] mem_data;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(
        .MAX_WAIT (16),
        .CNT_W    (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!bus.mem_req || bus.mem_ready) mem_cnt <= 0;
        else                               mem_cnt <= mem_cnt + 1;
    end

    assign bus.mem_ready = bus.mem_req && mem_en && (mem_cnt == mem_delay - 1);
    assign bus.mem_rdata = mem_data;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        n_checks++;
        if (bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mem_ctl: got req=%b we=%b want 0 0", bus.mem_req, bus.mem_we);
        end
        n_checks++;
        if (bus.mem_addr !== 30'h0 || bus.mem_wdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mem_data: got addr=%h wdata=%h want 0 0", bus.mem_addr, bus.mem_wdata);
        end
        n_checks++;
        if (bus.if_rdata !== 32'h0 || bus.dm_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_rdata: got if=%h dm=%h want 0 0", bus.if_rdata, bus.dm_rdata);
        end
        n_checks++;
        if (bus.if_done !== 1'b0 || bus.dm_done !== 1'b0 || bus.bus_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got if_done=%b dm_done=%b bus_err=%b want 0 0 0",
                     bus.if_done, bus.dm_done, bus.bus_err);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_fetch();
        mem_en = 1'b1; mem_delay = 1; mem_data = 32'h3C010001;
        bus.if_req = 1'b1; bus.if_addr = 30'h100;
        #1;
        n_checks++;
        if (bus.stall_if !== 1'b1) begin
            n_fail++; $display("FAIL fetch_stall_req: got %b want 1", bus.stall_if);
        end
        step();
        n_checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 30'h100 || bus.mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_grant: got req=%b addr=%h we=%b want 1 100 0", bus.mem_req, bus.mem_addr, bus.mem_we);
        end
        n_checks++;
        if (bus.if_done !== 1'b0 || bus.stall_if !== 1'b1) begin
            n_fail++; $display("FAIL fetch_busy: got done=%b stall=%b want 0 1", bus.if_done, bus.stall_if);
        end
        step();
        n_checks++;
        if (bus.if_done !== 1'b1 || bus.if_rdata !== 32'h3C010001 || bus.stall_if !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_done: got done=%b rdata=%h stall=%b want 1 3c010001 0",
                     bus.if_done, bus.if_rdata, bus.stall_if);
        end
        n_checks++;
        if (bus.mem_req !== 1'b0 || bus.dm_done !== 1'b0) begin
            n_fail++; $display("FAIL fetch_release: got mem_req=%b dm_done=%b want 0 0", bus.mem_req, bus.dm_done);
        end
        bus.if_req = 1'b0;
        step();
        n_checks++;
        if (bus.if_done !== 1'b0 || bus.mem_req !== 1'b0) begin
            n_fail++; $display("FAIL fetch_single_pulse: got done=%b mem_req=%b want 0 0", bus.if_done, bus.mem_req);
        end
    endtask

    task automatic test_simultaneous();
        mem_delay = 1; mem_data = 32'h11112222;
        bus.if_req = 1'b1; bus.if_addr = 30'h104;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 30'h200;
        step();
        n_checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 30'h200 || bus.mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_dm_first: got req=%b addr=%h we=%b want 1 200 0", bus.mem_req, bus.mem_addr, bus.mem_we);
        end
        step();
        n_checks++;
        if (bus.dm_done !== 1'b1 || bus.dm_rdata !== 32'h11112222 || bus.if_done !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_dm_done: got dm_done=%b rdata=%h if_done=%b want 1 11112222 0",
                     bus.dm_done, bus.dm_rdata, bus.if_done);
        end
        n_checks++;
        if (bus.stall_mem !== 1'b0 || bus.stall_if !== 1'b1) begin
            n_fail++; $display("FAIL simul_stalls: got mem=%b if=%b want 0 1", bus.stall_mem, bus.stall_if);
        end
        bus.dm_req = 1'b0;
        mem_data = 32'h33334444;
        step();
        n_checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 30'h104 || bus.mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_if_grant: got req=%b addr=%h we=%b want 1 104 0", bus.mem_req, bus.mem_addr, bus.mem_we);
        end
        step();
        n_checks++;
        if (bus.if_done !== 1'b1 || bus.if_rdata !== 32'h33334444 || bus.dm_rdata !== 32'h11112222) begin
            n_fail++;
            $display("FAIL simul_if_done: got done=%b if_rdata=%h dm_rdata=%h want 1 33334444 11112222",
                     bus.if_done, bus.if_rdata, bus.dm_rdata);
        end
        bus.if_req = 1'b0;
        step();
    endtask

    task automatic test_store();
        mem_delay = 3; mem_data = 32'hCAFEF00D;
        bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 30'h0F0; bus.dm_wdata = 32'hDEADBEEF;
        for (int k = 1; k <= 3; k++) begin
            step();
            n_checks++;
            if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 30'h0F0 ||
                bus.mem_wdata !== 32'hDEADBEEF || bus.dm_done !== 1'b0) begin
                n_fail++;
                $display("FAIL store_hold cycle %0d: got req=%b we=%b addr=%h wdata=%h done=%b want 1 1 0f0 deadbeef 0",
                         k, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.dm_done);
            end
        end
        step();
        n_checks++;
        if (bus.dm_done !== 1'b1 || bus.dm_rdata !== 32'h11112222 || bus.mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL store_done: got done=%b dm_rdata=%h mem_req=%b want 1 11112222 0",
                     bus.dm_done, bus.dm_rdata, bus.mem_req);
        end
        bus.dm_req = 1'b0; bus.dm_we = 1'b0;
        step();
    endtask

    task automatic test_no_preempt();
        mem_delay = 4; mem_data = 32'h0BADC0DE;
        bus.if_req = 1'b1; bus.if_addr = 30'h180;
        step();
        step();
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 30'h2A0;
        for (int k = 2; k <= 4; k++) begin
            #1;
            n_checks++;
            if (bus.mem_addr !== 30'h180 || bus.mem_req !== 1'b1 || bus.stall_mem !== 1'b1) begin
                n_fail++;
                $display("FAIL nopreempt_hold cycle %0d: got addr=%h req=%b stall_mem=%b want 180 1 1",
                         k, bus.mem_addr, bus.mem_req, bus.stall_mem);
            end
            step();
        end
        n_checks++;
        if (bus.if_done !== 1'b1 || bus.if_rdata !== 32'h0BADC0DE || bus.dm_done !== 1'b0) begin
            n_fail++;
            $display("FAIL nopreempt_if_done: got if_done=%b rdata=%h dm_done=%b want 1 0badc0de 0",
                     bus.if_done, bus.if_rdata, bus.dm_done);
        end
        bus.if_req = 1'b0;
        mem_delay = 1; mem_data = 32'h12345678;
        step();
        n_checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 30'h2A0) begin
            n_fail++; $display("FAIL nopreempt_dm_grant: got req=%b addr=%h want 1 2a0", bus.mem_req, bus.mem_addr);
        end
        step();
        n_checks++;
        if (bus.dm_done !== 1'b1 || bus.dm_rdata !== 32'h12345678) begin
            n_fail++; $display("FAIL nopreempt_dm_done: got done=%b rdata=%h want 1 12345678", bus.dm_done, bus.dm_rdata);
        end
        bus.dm_req = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        n_checks++;
        if (bus.bus_err !== 1'b0) begin
            n_fail++; $display("FAIL timeout_pre_err: got %b want 0", bus.bus_err);
        end
        mem_en = 1'b0;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 30'h3FF;
        for (int k = 1; k <= 16; k++) begin
            step();
            n_checks++;
            if (bus.mem_req !== 1'b1 || bus.dm_done !== 1'b0) begin
                n_fail++;
                $display("FAIL timeout_wait cycle %0d: got req=%b done=%b want 1 0", k, bus.mem_req, bus.dm_done);
            end
        end
        step();
        n_checks++;
        if (bus.dm_done !== 1'b1 || bus.dm_rdata !== 32'h0 || bus.bus_err !== 1'b1 || bus.mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_abort: got done=%b rdata=%h err=%b req=%b want 1 0 1 0",
                     bus.dm_done, bus.dm_rdata, bus.bus_err, bus.mem_req);
        end
        bus.dm_req = 1'b0;
        mem_en = 1'b1; mem_delay = 1; mem_data = 32'h55AA55AA;
        step();
        bus.if_req = 1'b1; bus.if_addr = 30'h10;
        step();
        step();
        n_checks++;
        if (bus.if_done !== 1'b1 || bus.if_rdata !== 32'h55AA55AA || bus.bus_err !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_sticky: got done=%b rdata=%h err=%b want 1 55aa55aa 1",
                     bus.if_done, bus.if_rdata, bus.bus_err);
        end
        bus.if_req = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        mem_en = 1'b0;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 30'h123;
        step();
        step();
        n_checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 30'h123) begin
            n_fail++; $display("FAIL rstmid_busy: got req=%b addr=%h want 1 123", bus.mem_req, bus.mem_addr);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (bus.mem_req !== 1'b0 || bus.mem_addr !== 30'h0 || bus.bus_err !== 1'b0 ||
            bus.if_rdata !== 32'h0 || bus.dm_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL rstmid_async: got req=%b addr=%h err=%b if_rdata=%h dm_rdata=%h want 0 0 0 0 0",
                     bus.mem_req, bus.mem_addr, bus.bus_err, bus.if_rdata, bus.dm_rdata);
        end
        step();
        n_checks++;
        if (bus.dm_done !== 1'b0 || bus.mem_req !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_no_done: got done=%b req=%b want 0 0", bus.dm_done, bus.mem_req);
        end
        rst = 1'b0;
        mem_en = 1'b1; mem_delay = 1; mem_data = 32'h77778888;
        step();
        n_checks++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 30'h123 || bus.mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_regrant: got req=%b addr=%h we=%b want 1 123 0", bus.mem_req, bus.mem_addr, bus.mem_we);
        end
        step();
        n_checks++;
        if (bus.dm_done !== 1'b1 || bus.dm_rdata !== 32'h77778888 || bus.bus_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_after: got done=%b rdata=%h err=%b want 1 77778888 0",
                     bus.dm_done, bus.dm_rdata, bus.bus_err);
        end
        bus.dm_req = 1'b0;
        step();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        mem_en = 1'b1; mem_delay = 1; mem_data = 32'h0;
        rst = 1'b1;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
        test_reset();
        test_fetch();
        test_simultaneous();
        test_store();
        test_no_preempt();
        test_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
